// File: rtl/ring_arbiter.sv
// ---------------------------------------------------------------------------
// ring_arbiter
//
// Round-robin arbiter sharing one resource among NREQ requesters. A one-hot
// priority token decides where the circular winner search starts. Grants are
// registered, and each owner may hold the grant for at most MAX_HOLD
// consecutive cycles while someone else is waiting.
//
// Ports:
//   clk_2      board clock, all state updates on its rising edge
//   reset      synchronous active-high reset, wins over everything
//   enable     1 = arbitration allowed, 0 = release grant and freeze token
//   req        level-sensitive request per requester
//   grant      registered one-hot grant, zero when idle
//   grant_idx  index of the current owner, 0 when idle
//   busy       1 while any grant bit is set
//   hold_cnt   cycles the current owner has held the grant (saturates)
//   SEG        7-segment code of the owner number 1..4, 0 when idle
// ---------------------------------------------------------------------------
module ring_arbiter #(
   parameter int NREQ      = 4,
   parameter int MAX_HOLD  = 3,
   parameter int NBITS_SEG = 8
) (
   input  logic                 clk_2,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [NREQ-1:0]      req,
   output logic [NREQ-1:0]      grant,
   output logic [1:0]           grant_idx,
   output logic                 busy,
   output logic [2:0]           hold_cnt,
   output logic [NBITS_SEG-1:0] SEG
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } stateT;

   stateT            state_q;
   logic [NREQ-1:0]  grant_q;
   logic [NREQ-1:0]  prio_q;
   logic [2:0]       hold_q;

   logic [IW-1:0]    startIdx;
   logic [IW-1:0]    scanIdx;
   logic [NREQ-1:0]  candMask;
   logic [NREQ-1:0]  winnerOh;
   logic [NREQ-1:0]  prio_d;
   logic             winnerFound;
   logic             ownerReq;
   logic [7:0]       segCode;

   // Circular winner search starting at the token position. The current
   // owner is masked out of the candidates: in IDLE grant_q is zero so
   // nothing is masked, and in GRANT the search is only consulted on a
   // release or a forced rotation, where the owner must not win again.
   // The next token is the winner rotated left by one so the winner ends up
   // with the lowest priority.
   always_comb begin
      startIdx    = '0;
      scanIdx     = '0;
      winnerOh    = '0;
      winnerFound = 1'b0;
      candMask    = req & ~grant_q;
      for (int i = 0; i < NREQ; i++) begin
         if (prio_q[i]) begin
            startIdx = IW'(i);
         end
      end
      for (int k = 0; k < NREQ; k++) begin
         scanIdx = IW'((int'(startIdx) + k) % NREQ);
         if (!winnerFound && candMask[scanIdx]) begin
            winnerFound       = 1'b1;
            winnerOh[scanIdx] = 1'b1;
         end
      end
      prio_d   = {winnerOh[NREQ-2:0], winnerOh[NREQ-1]};
      ownerReq = |(req & grant_q);
   end

   // Arbitration state machine. Disabling drops the grant but leaves the
   // token where it was, so fairness continues once enable returns. A
   // release hands over directly to the next requester without an idle
   // bubble; an owner that hits the hold limit is rotated out only if
   // someone else is actually waiting, otherwise it keeps the grant with the
   // counter parked at MAX_HOLD.
   always_ff @(posedge clk_2) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         hold_q  <= '0;
         prio_q  <= NREQ'(1);
      end else if (!enable) begin
         state_q <= IDLE;
         grant_q <= '0;
         hold_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (winnerFound) begin
                  state_q <= GRANT;
                  grant_q <= winnerOh;
                  hold_q  <= 3'd1;
                  prio_q  <= prio_d;
               end else begin
                  grant_q <= '0;
                  hold_q  <= '0;
               end
            end
            GRANT: begin
               if (!ownerReq) begin
                  if (winnerFound) begin
                     grant_q <= winnerOh;
                     hold_q  <= 3'd1;
                     prio_q  <= prio_d;
                  end else begin
                     state_q <= IDLE;
                     grant_q <= '0;
                     hold_q  <= '0;
                  end
               end else if (hold_q < 3'(MAX_HOLD)) begin
                  hold_q <= hold_q + 3'd1;
               end else if (winnerFound) begin
                  grant_q <= winnerOh;
                  hold_q  <= 3'd1;
                  prio_q  <= prio_d;
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
               hold_q  <= '0;
            end
         endcase
      end
   end

   // Owner index, busy flag and display code are all decoded from the
   // registered grant, so they change exactly when the grant does.
   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_q[i]) begin
            grant_idx = 2'(i);
         end
      end
      busy = |grant_q;
      case (grant_idx)
         2'd0:    segCode = 8'b00000110;
         2'd1:    segCode = 8'b01011011;
         2'd2:    segCode = 8'b01001111;
         default: segCode = 8'b01100110;
      endcase
      if (!busy) begin
         segCode = 8'b00000000;
      end
   end

   assign grant    = grant_q;
   assign hold_cnt = hold_q;
   assign SEG      = NBITS_SEG'(segCode);

endmodule

// File: tb/tb_ring_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ring_arbiter
//
// Scoreboard bench for ring_arbiter. The driver applies inputs on the
// falling edge, steps a behavioural model (owner number, hold count and a
// priority pointer kept as plain integers) and pushes the expected outputs
// into a queue. An independent monitor samples the DUT just after each
// rising edge and compares against the queued expectation. A directed
// sequence walks the interesting scenarios, then randomized traffic follows.
// ---------------------------------------------------------------------------
module tb_ring_arbiter;

   localparam int MAXH = 3;

   typedef struct packed {
      logic [3:0] grant;
      logic [1:0] idx;
      logic       busy;
      logic [2:0] hold;
      logic [7:0] seg;
   } expT;

   logic       clk_2;
   logic       reset;
   logic       enable;
   logic [3:0] req;
   logic [3:0] grant;
   logic [1:0] grant_idx;
   logic       busy;
   logic [2:0] hold_cnt;
   logic [7:0] SEG;

   expT        expQ[$];
   int         checks;
   int         errors;
   int         mOwner;
   int         mHold;
   int         mPtr;
   logic [7:0] segTable [4];

   ring_arbiter #(
      .NREQ      (4),
      .MAX_HOLD  (MAXH),
      .NBITS_SEG (8)
   ) dut (
      .clk_2     (clk_2),
      .reset     (reset),
      .enable    (enable),
      .req       (req),
      .grant     (grant),
      .grant_idx (grant_idx),
      .busy      (busy),
      .hold_cnt  (hold_cnt),
      .SEG       (SEG)
   );

   // Free-running board clock, 10 time units per period.
   initial begin
      clk_2 = 1'b0;
      forever #5 clk_2 = ~clk_2;
   end

   // Search the requesters circularly from the pointer, skipping one
   // excluded requester; -1 means nobody is asking.
   function automatic int pickWinner(input logic [3:0] r, input int ptr, input int excl);
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (ptr + k) % 4;
         if (i != excl && r[i]) begin
            return i;
         end
      end
      return -1;
   endfunction

   // Advance the model by one clock edge using the arbitration rules.
   task automatic modelStep(input logic rst, input logic en, input logic [3:0] r);
      int w;
      if (rst) begin
         mOwner = -1;
         mHold  = 0;
         mPtr   = 0;
      end else if (!en) begin
         mOwner = -1;
         mHold  = 0;
      end else if (mOwner < 0) begin
         w = pickWinner(r, mPtr, -1);
         if (w >= 0) begin
            mOwner = w;
            mHold  = 1;
            mPtr   = (w + 1) % 4;
         end
      end else if (!r[mOwner] || mHold >= MAXH) begin
         w = pickWinner(r, mPtr, mOwner);
         if (w >= 0) begin
            mOwner = w;
            mHold  = 1;
            mPtr   = (w + 1) % 4;
         end else if (!r[mOwner]) begin
            mOwner = -1;
            mHold  = 0;
         end
      end else begin
         mHold = mHold + 1;
      end
   endtask

   // Drive one cycle of inputs on the falling edge and queue what the DUT
   // must show after the following rising edge.
   task automatic applyStimulus(input logic rst, input logic en, input logic [3:0] r);
      expT e;
      @(negedge clk_2);
      reset  = rst;
      enable = en;
      req    = r;
      modelStep(rst, en, r);
      e.grant = (mOwner < 0) ? 4'b0000 : 4'(1 << mOwner);
      e.idx   = (mOwner < 0) ? 2'd0 : 2'(mOwner);
      e.busy  = (mOwner >= 0);
      e.hold  = 3'(mHold);
      e.seg   = (mOwner < 0) ? 8'h00 : segTable[mOwner];
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks = checks + 1;
      if (actual != expected) begin
         errors = errors + 1;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
      end
   endtask

   // Monitor: after every rising edge, compare the DUT against the oldest
   // queued expectation, independent of the driver.
   initial begin
      expT e;
      forever begin
         @(posedge clk_2);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("grant",     int'(grant),     int'(e.grant));
            checkOutput("grant_idx", int'(grant_idx), int'(e.idx));
            checkOutput("busy",      int'(busy),      int'(e.busy));
            checkOutput("hold_cnt",  int'(hold_cnt),  int'(e.hold));
            checkOutput("SEG",       int'(SEG),       int'(e.seg));
         end
      end
   end

   // Directed scenarios first, then randomized traffic with occasional
   // disable and reset pulses; finally make sure every expectation was used.
   initial begin
      checks = 0;
      errors = 0;
      mOwner = -1;
      mHold  = 0;
      mPtr   = 0;
      segTable[0] = 8'b00000110;
      segTable[1] = 8'b01011011;
      segTable[2] = 8'b01001111;
      segTable[3] = 8'b01100110;
      reset  = 1'b1;
      enable = 1'b0;
      req    = 4'b0000;

      $display("[TB] reset and single request");
      applyStimulus(1'b1, 1'b0, 4'b0000);
      applyStimulus(1'b1, 1'b1, 4'b0000);
      applyStimulus(1'b0, 1'b1, 4'b0001);
      applyStimulus(1'b0, 1'b1, 4'b0000);

      $display("[TB] all requesting, forced rotation");
      applyStimulus(1'b1, 1'b1, 4'b1111);
      for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b1, 4'b1111);

      $display("[TB] release with direct handover and release to idle");
      applyStimulus(1'b1, 1'b1, 4'b0000);
      applyStimulus(1'b0, 1'b1, 4'b0100);
      applyStimulus(1'b0, 1'b1, 4'b1001);
      applyStimulus(1'b1, 1'b1, 4'b0000);
      applyStimulus(1'b0, 1'b1, 4'b0100);
      applyStimulus(1'b0, 1'b1, 4'b0000);

      $display("[TB] single requester saturates hold count");
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 4'b0100);

      $display("[TB] disable mid-grant keeps token");
      applyStimulus(1'b1, 1'b1, 4'b0000);
      applyStimulus(1'b0, 1'b1, 4'b0010);
      applyStimulus(1'b0, 1'b0, 4'b1111);
      applyStimulus(1'b0, 1'b1, 4'b1111);

      $display("[TB] reset mid-grant");
      applyStimulus(1'b1, 1'b1, 4'b0000);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 4'b1111);
      applyStimulus(1'b1, 1'b1, 4'b1111);
      applyStimulus(1'b0, 1'b1, 4'b1111);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 500; i++) begin
         logic       rRst;
         logic       rEn;
         logic [3:0] rReq;
         rRst = ($urandom_range(0, 63) == 0);
         rEn  = ($urandom_range(0, 15) != 0);
         rReq = 4'($urandom);
         if ($urandom_range(0, 3) == 0) rReq = 4'b0000;
         applyStimulus(rRst, rEn, rReq);
      end

      repeat (3) @(negedge clk_2);
      checkOutput("queue_drained", expQ.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
